multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port instr, input, 32 bits: fetched instruction. func = instr[31:27]; type = instr[2:1], where 00 = R, 01 = J, 10 = I, 11 = S.
REQ-004 SHALL have port instr_valid, input, 1 bit: fetch unit holds a valid instruction.
REQ-005 SHALL have port zero, input, 1 bit: ALU equality flag, used for BEQ.
REQ-006 SHALL have port mem_ready, input, 1 bit: data memory has completed the access.
REQ-007 SHALL have port pc_src, output, 2 bits: 00 = PC+1, 01 = jump address, 10 = branch target.
REQ-008 SHALL have port pc_write, output, 1 bit: PC update strobe.
REQ-009 SHALL have port ir_write, output, 1 bit: instruction register load strobe.
REQ-010 SHALL have ports reg_write, mem_read and mem_write, outputs, 1 bit each.
REQ-011 SHALL have port alu_src, output, 1 bit: 0 = register, 1 = immediate.
REQ-012 SHALL have port alu_op, output, 3 bits: 000 = AND, 001 = ADD, 010 = SUB, 011 = CAM, 100 = SLL, 101 = SLR.
REQ-013 SHALL have port wb_sel, output, 2 bits: 00 = ALU, 01 = memory, 10 = return address (PC).
REQ-014 SHALL have port illegal, output, 1 bit: one-cycle pulse on an undecodable instruction.
REQ-015 SHALL have port state, output, 3 bits: current state encoding.
REQ-016 SHALL have ports cycle_cnt and instr_cnt, outputs, 32 bits each: performance counters.

Function
REQ-017 SHALL implement states FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3 and WB = 4; encodings 5 to 7 SHALL recover to FETCH on the next edge.
REQ-018 SHALL remain in FETCH while instr_valid = 0, with all strobes at 0.
REQ-019 In FETCH with instr_valid = 1, SHALL assert ir_write = 1, pc_write = 1 and pc_src = 00 for that cycle, then go to DECODE.
REQ-020 Legal I-type funcs SHALL be 0 to 4 (ANDI, ADDI, LW, SW, BEQ); R-type 0 to 3 (AND, ADD, SUB, CAM); J-type 0 to 1 (J, JAL); S-type 0 to 3 (SLL, SLR, SLLV, SLRV).
REQ-021 R, S, ANDI and ADDI SHALL follow FETCH -> DECODE -> EXEC -> WB -> FETCH, with reg_write = 1 and wb_sel = 00 in WB.
REQ-022 LW SHALL follow FETCH -> DECODE -> EXEC -> MEM -> WB -> FETCH; mem_read = 1 in MEM; wb_sel = 01 and reg_write = 1 in WB.
REQ-023 SW SHALL follow FETCH -> DECODE -> EXEC -> MEM -> FETCH, with mem_write = 1 in MEM.
REQ-024 SHALL hold MEM while mem_ready = 0, keeping mem_read or mem_write asserted; it SHALL leave MEM on the edge where mem_ready = 1.
REQ-025 BEQ SHALL follow FETCH -> DECODE -> EXEC -> FETCH; in EXEC, alu_op = SUB, and pc_write = 1 with pc_src = 10 only when zero = 1 (Mealy output).
REQ-026 J SHALL follow FETCH -> DECODE -> FETCH, with pc_write = 1 and pc_src = 01 in DECODE.
REQ-027 JAL SHALL behave as J and then pass through WB, with reg_write = 1 and wb_sel = 10.
REQ-028 alu_src SHALL be 1 in EXEC for ANDI, ADDI, LW and SW, and 0 otherwise.
REQ-029 alu_op SHALL be ADD for LW and SW; S-type funcs 0 and 2 SHALL map to SLL; S-type funcs 1 and 3 SHALL map to SLR.
REQ-030 An illegal type/func combination SHALL pulse illegal = 1 in DECODE, assert no other strobe, and return to FETCH.
REQ-031 All outputs other than those stated SHALL be 0 in each state; at most one of mem_read and mem_write SHALL be 1.
REQ-032 An instruction SHALL retire on the last cycle of its sequence, as it transitions to FETCH; an illegal instruction SHALL NOT retire.

Reset
REQ-033 While reset = 1, state SHALL be FETCH and every other output SHALL be 0, including both counters.
REQ-034 Reset asserted mid-instruction SHALL abort it immediately, with no strobe leaking out.
REQ-035 Fetching SHALL resume on the first rising edge after reset deasserts.

Configuration
REQ-036 With MC_PERF_CNT_EN defined, cycle_cnt SHALL increment on every clock edge outside reset.
REQ-037 With MC_PERF_CNT_EN defined, instr_cnt SHALL increment on each retirement.
REQ-038 Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-039 Without MC_PERF_CNT_EN, both counters SHALL be constant 0 and no counter flops SHALL be synthesized.

Verification
REQ-040 Bench SHALL drive ADD (0x0CC07000), instr_valid = 1 -> states 0,1,2,4,0; reg_write = 1 only in the 4th cycle; instr_cnt = 1.
REQ-041 Bench SHALL drive LW (0x10000034) with mem_ready low for 3 cycles -> MEM held 4 cycles with mem_read = 1; then WB with wb_sel = 01; total 8 cycles.
REQ-042 Bench SHALL drive BEQ (0x21CE0084) with zero = 1, then again with zero = 0 -> pc_write/pc_src = 1/10 in EXEC for the first only; 3 cycles each.
REQ-043 Bench SHALL drive JAL (0x08001F42) -> DECODE gives pc_write = 1, pc_src = 01; WB gives reg_write = 1, wb_sel = 10; the I-type func-7 instruction 0x38000004 then gives illegal = 1 and instr_cnt unchanged.
REQ-044 Bench SHALL assert reset during MEM of an SW -> mem_write drops to 0 asynchronously, state = 0, and counters = 0.
REQ-045 Bench SHALL, with MC_PERF_CNT_EN defined, preload cycle_cnt = 0xFFFFFFFF by force -> 0 on the next edge.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer that
// drives the datapath strobes for R, I, J and S instruction types.
// Optional performance counters (cycle_cnt, instr_cnt) are built only when
// MC_PERF_CNT_EN is defined; otherwise both read as constant zero.
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [1:0]  pc_src,
    output logic        pc_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    // Instruction classes: everything the sequencer needs after FETCH
    typedef enum logic [2:0] {
        OP_ALU, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ILL
    } op_t;

    localparam logic [1:0] TYPE_R = 2'b00;
    localparam logic [1:0] TYPE_J = 2'b01;
    localparam logic [1:0] TYPE_I = 2'b10;
    localparam logic [1:0] TYPE_S = 2'b11;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_CAM = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SLR = 3'b101;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    state_t     state_q;
    op_t        op_q;
    logic [2:0] aluop_q;
    logic       imm_q;

    // Only func and type fields steer control; the rest belongs to the datapath
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[26:3], instr[0]};

    function automatic op_t decode_op(input logic [1:0] typ, input logic [4:0] func);
        op_t op;
        op = OP_ILL;
        case (typ)
            TYPE_R, TYPE_S: if (func <= 5'd3) op = OP_ALU;
            TYPE_J: begin
                if (func == 5'd0)      op = OP_J;
                else if (func == 5'd1) op = OP_JAL;
            end
            TYPE_I: begin
                case (func)
                    5'd0, 5'd1: op = OP_ALU;
                    5'd2:       op = OP_LW;
                    5'd3:       op = OP_SW;
                    5'd4:       op = OP_BEQ;
                    default:    op = OP_ILL;
                endcase
            end
            default: op = OP_ILL;
        endcase
        return op;
    endfunction

    function automatic logic [2:0] decode_aluop(input logic [1:0] typ, input logic [4:0] func);
        logic [2:0] a;
        a = ALU_AND;
        case (typ)
            TYPE_R: begin
                case (func)
                    5'd1:    a = ALU_ADD;
                    5'd2:    a = ALU_SUB;
                    5'd3:    a = ALU_CAM;
                    default: a = ALU_AND;
                endcase
            end
            TYPE_I: begin
                case (func)
                    5'd1, 5'd2, 5'd3: a = ALU_ADD;   // ADDI and LW/SW address add
                    5'd4:             a = ALU_SUB;   // BEQ compares by subtraction
                    default:          a = ALU_AND;
                endcase
            end
            TYPE_S: begin
                case (func)
                    5'd1, 5'd3: a = ALU_SLR;
                    default:    a = ALU_SLL;
                endcase
            end
            default: a = ALU_AND;
        endcase
        return a;
    endfunction

    // Sequencer: latch the decoded class at fetch, then walk the instruction's phases
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            op_q    <= OP_ILL;
            aluop_q <= ALU_AND;
            imm_q   <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (instr_valid) begin
                        op_q    <= decode_op(instr[2:1], instr[31:27]);
                        aluop_q <= decode_aluop(instr[2:1], instr[31:27]);
                        imm_q   <= (instr[2:1] == TYPE_I) && (instr[31:27] <= 5'd3);
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    case (op_q)
                        OP_ILL, OP_J: state_q <= FETCH;
                        OP_JAL:       state_q <= WB;
                        default:      state_q <= EXEC;
                    endcase
                end
                EXEC: begin
                    case (op_q)
                        OP_BEQ:       state_q <= FETCH;
                        OP_LW, OP_SW: state_q <= MEM;
                        default:      state_q <= WB;
                    endcase
                end
                MEM: begin
                    if (mem_ready) state_q <= (op_q == OP_LW) ? WB : FETCH;
                end
                WB:      state_q <= FETCH;
                default: state_q <= FETCH;
            endcase
        end
    end

    assign state = state_q;

    // Strobes decode from the current state and live inputs so that the fetch
    // handshake, branch decision and memory wait act in the same cycle, and so
    // that asserting reset silences every strobe without waiting for a clock.
    always_comb begin
        pc_src    = PC_NEXT;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_src   = 1'b0;
        alu_op    = ALU_AND;
        wb_sel    = WB_ALU;
        illegal   = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    if (instr_valid) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_NEXT;
                    end
                end
                DECODE: begin
                    if (op_q == OP_ILL) begin
                        illegal = 1'b1;
                    end else if (op_q == OP_J || op_q == OP_JAL) begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                    end
                end
                EXEC: begin
                    alu_op  = aluop_q;
                    alu_src = imm_q;
                    if (op_q == OP_BEQ && zero) begin
                        pc_write = 1'b1;
                        pc_src   = PC_BRANCH;
                    end
                end
                MEM: begin
                    mem_read  = (op_q == OP_LW);
                    mem_write = (op_q == OP_SW);
                end
                WB: begin
                    reg_write = 1'b1;
                    if (op_q == OP_LW)       wb_sel = WB_MEM;
                    else if (op_q == OP_JAL) wb_sel = WB_PC;
                    else                     wb_sel = WB_ALU;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_q;
    logic [31:0] instr_q;
    logic        retire;

    // An instruction retires on the edge that returns the sequencer to FETCH
    assign retire = ((state_q == DECODE) && (op_q == OP_J))
                 || ((state_q == EXEC)   && (op_q == OP_BEQ))
                 || ((state_q == MEM)    && (op_q == OP_SW) && mem_ready)
                 ||  (state_q == WB);

    // Free-running cycle counter and retired-instruction counter, both wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q <= 32'd0;
            instr_q <= 32'd0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (retire) instr_q <= instr_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_q;
`else
    assign cycle_cnt = 32'd0;
    assign instr_cnt = 32'd0;
`endif

endmodule
